// File: rtl/beep_period_meter.sv
// Measures rising-edge-to-rising-edge period of an asynchronous square wave in clk cycles.
// Single or continuous mode, with a timeout when no edge arrives within MAX_PERIOD.
module beep_period_meter #(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] MAX_PERIOD = CNT_W'(50_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  input  logic             mode,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state;
  logic [1:0]       sync;
  logic             hist;
  logic             edge_det;
  logic             mode_lat;
  logic [CNT_W-1:0] cnt;

  assign busy = (state == ARM) || (state == MEASURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync         <= '0;
      hist         <= 1'b0;
      edge_det     <= 1'b0;
      mode_lat     <= 1'b0;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sync         <= {sync[0], sig_in};
      hist         <= sync[1];
      edge_det     <= sync[1] & ~hist;
      period_valid <= 1'b0;
      timeout      <= 1'b0;

      // Dropping meas_en wins over everything, including a coincident edge.
      if (!meas_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ARM;
            mode_lat <= mode;
            cnt      <= '0;
          end
          ARM: begin
            if (edge_det) begin
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            // An edge at the limit still counts as a valid period.
            if (edge_det) begin
              period_out   <= cnt;
              period_valid <= 1'b1;
              cnt          <= CNT_W'(1);
              state        <= mode_lat ? MEASURE : DONE;
            end else if (cnt == MAX_PERIOD) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ARM;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beep_period_meter.sv
// Scoreboarded bench: stimulus predicts each valid/timeout pulse (value and cycle), a monitor pops and compares.
module tb_beep_period_meter;

  localparam int MAXP = 2000;
  localparam int S_IDLE = 0, S_ARM = 1, S_MEAS = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        meas_en;
  logic        mode;
  logic [31:0] period_out;
  logic        period_valid;
  logic        timeout;
  logic        busy;

  typedef struct {
    bit is_to;
    int val;
    int cyc;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  m_state = S_IDLE;
  int  m_last = 0;
  bit  m_mode = 1'b0;

  beep_period_meter #(.CNT_W(32), .MAX_PERIOD(32'(MAXP))) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en), .mode(mode),
    .period_out(period_out), .period_valid(period_valid), .timeout(timeout), .busy(busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (period_valid && timeout) begin
        checks++;
        failures++;
        $display("FAIL both_pulses valid and timeout high together at cyc=%0d", cyc);
      end else if (period_valid || timeout) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event valid=%0b timeout=%0b period_out=%0d cyc=%0d required=none",
                   period_valid, timeout, period_out, cyc);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          if (e.is_to != timeout || (!e.is_to && int'(period_out) != e.val) || cyc != e.cyc) begin
            failures++;
            $display("FAIL event actual: timeout=%0b period_out=%0d cyc=%0d required: timeout=%0b period_out=%0d cyc=%0d",
                     timeout, period_out, cyc, e.is_to, e.val, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Edge driven at negedge cyc==n reaches the FSM output registers at cyc n+4.
  task automatic rise();
    int ev;
    sig_in = 1'b1;
    ev = cyc + 4;
    case (m_state)
      S_ARM: begin
        m_state = S_MEAS;
        m_last  = ev;
      end
      S_MEAS: begin
        sbq.push_back('{is_to: 1'b0, val: ev - m_last, cyc: ev});
        m_last = ev;
        if (!m_mode) m_state = S_DONE;
      end
      default: ;
    endcase
  endtask

  task automatic wave(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      rise();
      tick(per / 2);
      sig_in = 1'b0;
      tick(per - per / 2);
    end
  endtask

  task automatic set_en(input bit v);
    meas_en = v;
    if (v && m_state == S_IDLE) begin
      m_state = S_ARM;
      m_mode  = mode;
    end
    if (!v) m_state = S_IDLE;
  endtask

  initial begin
    rst = 1'b1; sig_in = 1'b0; meas_en = 1'b0; mode = 1'b0;
    tick(3);
    check("rst_period_out", int'(period_out), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick(5);

    // Continuous at 1000, then switch to 600 (first 600-rise gives a 1000 transitional value)
    mode = 1'b1;
    set_en(1'b1);
    tick(10);
    wave(1000, 5);
    check("cont_busy", int'(busy), 1);
    wave(600, 5);
    set_en(1'b0);
    tick(20);
    check("idle_busy", int'(busy), 0);
    check("idle_hold_period", int'(period_out), 600);

    // Single mode; the later mode change must be ignored
    mode = 1'b0;
    set_en(1'b1);
    tick(10);
    mode = 1'b1;
    wave(600, 4);
    check("done_busy", int'(busy), 0);
    check("done_hold_period", int'(period_out), 600);
    set_en(1'b0);
    tick(10);
    mode = 1'b0;
    set_en(1'b1);
    tick(10);
    wave(600, 3);
    check("done2_busy", int'(busy), 0);
    set_en(1'b0);
    tick(10);

    // Timeout: one edge then held low
    mode = 1'b1;
    set_en(1'b1);
    tick(10);
    rise();
    sbq.push_back('{is_to: 1'b1, val: 0, cyc: m_last + MAXP});
    m_state = S_ARM;
    tick(10);
    sig_in = 1'b0;
    tick(2100);
    check("timeout_busy_arm", int'(busy), 1);
    check("timeout_hold_period", int'(period_out), 600);

    // Edges exactly MAX_PERIOD apart
    wave(2000, 3);
    check("boundary_period", int'(period_out), 2000);

    // Reset mid-measure
    rise();
    tick(300);
    rst = 1'b1;
    meas_en = 1'b0;
    m_state = S_IDLE;
    tick(1);
    check("midrst_period_out", int'(period_out), 0);
    check("midrst_valid", int'(period_valid), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    sig_in = 1'b0;
    tick(10);
    set_en(1'b1);
    tick(10);
    wave(1000, 3);
    check("post_rst_period", int'(period_out), 1000);

    tick(50);
    check("queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
